// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync decode, line/frame pulses and frame counter.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/visible by one pixel.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_NEG  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] frame_cnt
);
  localparam logic [9:0] H_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX    = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic       POL      = (SYNC_NEG != 0);
  logic [9:0] r_hpos, r_vpos, r_frame_cnt;
  logic       r_hsync, r_vsync, r_visible, r_line_start, r_frame_start;
  logic       w_h_wrap, w_v_wrap, w_line, w_frame;
  logic [9:0] w_hpos_nxt, w_vpos_nxt;
  logic       w_hsync_nxt, w_vsync_nxt, w_visible_nxt;
  always_comb begin
    w_h_wrap      = (r_hpos == H_MAX);
    w_v_wrap      = (r_vpos == V_MAX);
    w_line        = pix_en && w_h_wrap;
    w_frame       = w_line && w_v_wrap;
    w_hpos_nxt    = pix_en ? (w_h_wrap ? 10'd0 : r_hpos + 10'd1) : r_hpos;
    w_vpos_nxt    = w_line ? (w_v_wrap ? 10'd0 : r_vpos + 10'd1) : r_vpos;
    // Decode from the next position so the registered levels line up with hpos/vpos.
    w_hsync_nxt   = ((w_hpos_nxt >= HS_FIRST) && (w_hpos_nxt <= HS_LAST)) ^ POL;
    w_vsync_nxt   = ((w_vpos_nxt >= VS_FIRST) && (w_vpos_nxt <= VS_LAST)) ^ POL;
    w_visible_nxt = (w_hpos_nxt < H_VIS) && (w_vpos_nxt < V_VIS);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_hsync       <= POL;
      r_vsync       <= POL;
      r_visible     <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_hpos        <= w_hpos_nxt;
      r_vpos        <= w_vpos_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_visible     <= w_visible_nxt;
      r_line_start  <= w_line;
      r_frame_start <= w_frame;
      if (w_frame) r_frame_cnt <= r_frame_cnt + 10'd1;
    end
  end
`ifdef VGA_SYNC_DELAY_EN
  logic r_hsync_d, r_vsync_d, r_visible_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hsync_d   <= POL;
      r_vsync_d   <= POL;
      r_visible_d <= 1'b0;
    end else if (pix_en) begin
      r_hsync_d   <= r_hsync;
      r_vsync_d   <= r_vsync;
      r_visible_d <= r_visible;
    end
  end
  assign hsync   = r_hsync_d;
  assign vsync   = r_vsync_d;
  assign visible = r_visible_d;
`else
  assign hsync   = r_hsync;
  assign vsync   = r_vsync;
  assign visible = r_visible;
`endif
  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random pix_en/reset stimulus against a linear pixel-index model
// on a small raster so 1024 frames fit in a short run.
module tb_vga_timing_gen;
  localparam int HD = 4, HF = 1, HS = 2, HB = 1;
  localparam int VD = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FR = HT * VT;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic [9:0] hpos, vpos, frame_cnt;
  logic hsync, vsync, visible, line_start, frame_start;
  int compared = 0;
  int mismatched = 0;
  int m_pix = 0, m_fc = 0, n_fs = 0;
  bit m_ls = 0, m_fs = 0;
  bit m_dh = 1, m_dv = 1, m_dvis = 0;
  always #5 clk = ~clk;
  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_NEG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hpos(hpos), .vpos(vpos),
    .hsync(hsync), .vsync(vsync), .visible(visible), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );
  function automatic bit hs_lvl(int p);
    int h = p % HT;
    return !(h >= HD + HF && h <= HD + HF + HS - 1);
  endfunction
  function automatic bit vs_lvl(int p);
    int v = p / HT;
    return !(v >= VD + VF && v <= VD + VF + VS - 1);
  endfunction
  function automatic bit vis(int p);
    return (p % HT) < HD && (p / HT) < VD;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (pix %0d)", tag, obs, exp, m_pix);
    end
  endtask
  task automatic step(input bit rn, input bit en);
    rst_n = rn;
    pix_en = en;
    @(posedge clk);
    if (!rn) begin
      m_pix = 0; m_ls = 0; m_fs = 0; m_fc = 0;
      m_dh = 1; m_dv = 1; m_dvis = 0;
    end else begin
      m_ls = 0; m_fs = 0;
      if (en) begin
        m_dh = hs_lvl(m_pix); m_dv = vs_lvl(m_pix); m_dvis = vis(m_pix);
        m_pix = (m_pix + 1) % FR;
        m_ls = (m_pix % HT) == 0;
        m_fs = m_pix == 0;
        if (m_fs) m_fc = (m_fc + 1) % 1024;
      end
    end
    #1;
    if (frame_start === 1'b1) n_fs++;
    chk("hpos", 32'(hpos), 32'(m_pix % HT));
    chk("vpos", 32'(vpos), 32'(m_pix / HT));
`ifdef VGA_SYNC_DELAY_EN
    chk("hsync", 32'(hsync), 32'(m_dh));
    chk("vsync", 32'(vsync), 32'(m_dv));
    chk("visible", 32'(visible), 32'(m_dvis));
`else
    chk("hsync", 32'(hsync), 32'(hs_lvl(m_pix)));
    chk("vsync", 32'(vsync), 32'(vs_lvl(m_pix)));
    chk("visible", 32'(visible), 32'(vis(m_pix)));
`endif
    chk("line_start", 32'(line_start), 32'(m_ls));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
  endtask
  initial begin
    step(0, 0);
    step(0, 1);
    step(1, 0);
    for (int i = 0; i < 3 * FR; i++) step(1, 1);
    for (int i = 0; i < 4 * FR; i++) step(1, i % 2 == 0);
    for (int i = 0; i < 4000; i++) step($urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1);
    for (int i = 0; i < 2 * HT + 3; i++) step(1, 1);
    step(0, 1);
    step(1, 0);
    step(0, 0);
    n_fs = 0;
    for (int i = 0; i < 1024 * FR; i++) step(1, 1);
    chk("frames_seen", 32'(n_fs), 32'd1024);
    chk("cnt_wrapped", 32'(frame_cnt), 32'd0);
    chk("last_fs", 32'(frame_start), 32'd1);
    for (int i = 0; i < 500; i++) step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
